// File: rtl/main_memory_resp.sv
// Word-addressed backing store that answers cache refills and write-throughs
// after a fixed latency, with a one-cycle completion pulse for each.
module main_memory_resp #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_read_en,
  input  logic                      mem_write_en,
  input  logic [31:0]               addr,
  input  logic [31:0]               wr_data,
  output logic [32*BLOCK_WORDS-1:0] rd_block,
  output logic                      ready_to_read,
  output logic                      finished_writing
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StWrWait,
    StRdDone,
    StWrDone
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [31:0]               data_q, data_d;
  logic [32*BLOCK_WORDS-1:0] rd_block_q;
  logic [31:0]               mem_q [MEM_DEPTH];
  logic                      mem_we;
  logic                      rd_load;
  logic [AW-1:0]             addr_idx;

  // Upper address bits are ignored so the store wraps modulo MEM_DEPTH.
  assign addr_idx = addr[AW+1:2];

  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    rd_load = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_write_en) begin
          idx_d   = addr_idx;
          data_d  = wr_data;
          cnt_d   = 4'(LATENCY - 1);
          state_d = StWrWait;
        end else if (mem_read_en) begin
          idx_d   = addr_idx & ~AW'(BLOCK_WORDS - 1);
          cnt_d   = 4'(LATENCY - 1);
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (!mem_read_en) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          rd_load = 1'b1;
          state_d = StRdDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrWait: begin
        if (!mem_write_en) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          mem_we  = 1'b1;
          state_d = StWrDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdDone, StWrDone: state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      rd_block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      if (rd_load) begin
        for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
          rd_block_q[32*i +: 32] <= mem_q[idx_q + AW'(i)];
        end
      end
    end
  end

  // Array is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign rd_block         = rd_block_q;
  assign ready_to_read    = (state_q == StRdDone);
  assign finished_writing = (state_q == StWrDone);

endmodule

// File: tb/tb_main_memory_resp.sv
// Directed bench for main_memory_resp with default parameters (1024 words,
// 4-word lines, latency 4).
module tb_main_memory_resp;

  localparam int ExpLat = 5;  // edges from driving a request to seeing its pulse

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read_en;
  logic         mem_write_en;
  logic [31:0]  addr;
  logic [31:0]  wr_data;
  logic [127:0] rd_block;
  logic         ready_to_read;
  logic         finished_writing;

  int n_vec = 0;
  int n_err = 0;

  main_memory_resp dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_en      (mem_read_en),
    .mem_write_en     (mem_write_en),
    .addr             (addr),
    .wr_data          (wr_data),
    .rd_block         (rd_block),
    .ready_to_read    (ready_to_read),
    .finished_writing (finished_writing)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request and wait (bounded) for the first completion pulse.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic sw,
                      output logic sr);
    mem_read_en  = rd;
    mem_write_en = wr;
    addr         = a;
    wr_data      = d;
    lat = 0;
    sw  = 1'b0;
    sr  = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (finished_writing) sw = 1'b1;
      if (ready_to_read) sr = 1'b1;
      if (sw || sr) begin
        lat = n;
        break;
      end
    end
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           lat;
    logic         sw, sr;
    logic [127:0] blk1;
    logic [31:0]  words [4];
    bit           seen;

    // Reset with both requests asserted: nothing may be accepted.
    reset        = 1'b1;
    mem_read_en  = 1'b1;
    mem_write_en = 1'b1;
    addr         = 32'h0;
    wr_data      = 32'hFFFF_FFFF;
    seen         = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (ready_to_read || finished_writing) seen = 1'b1;
    end
    check_eq("reset_no_pulse", {127'd0, seen}, 128'd0);
    check_eq("reset_rd_block", rd_block, 128'd0);
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    #1;

    // Fill line 1 (words 4..7), word 4 gets DEADBEEF at byte 0x10.
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h1111_0005;
    words[2] = 32'h2222_0006;
    words[3] = 32'h3333_0007;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 1'b1, 32'h10 + 32'(4 * i), words[i], lat, sw, sr);
      check_eq($sformatf("wr_lat_%0d", i), 128'(lat), 128'(ExpLat));
      check_eq($sformatf("wr_no_rd_%0d", i), {127'd0, sr}, 128'd0);
    end
    blk1 = {words[3], words[2], words[1], words[0]};
    xact(1'b1, 1'b0, 32'h14, 32'h0, lat, sw, sr);
    check_eq("rd_lat", 128'(lat), 128'(ExpLat));
    check_eq("rd_pulse_only", {126'd0, sw, sr}, 128'd1);
    check_eq("rd_block1", rd_block, blk1);

    // Both enables: write wins.
    xact(1'b1, 1'b1, 32'h20, 32'h1111_2222, lat, sw, sr);
    check_eq("both_lat", 128'(lat), 128'(ExpLat));
    check_eq("both_wr_only", {126'd0, sw, sr}, 128'd2);
    check_eq("both_block_held", rd_block, blk1);
    xact(1'b1, 1'b0, 32'h20, 32'h0, lat, sw, sr);
    check_eq("both_readback", 128'(rd_block[31:0]), 128'h1111_2222);

    // Read dropped after two edges: no pulse, rd_block unchanged.
    mem_read_en = 1'b1;
    addr        = 32'h14;
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_read_en = 1'b0;
    seen        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ready_to_read || finished_writing) seen = 1'b1;
    end
    check_eq("abort_no_pulse", {127'd0, seen}, 128'd0);
    check_eq("abort_block_held", 128'(rd_block[31:0]), 128'h1111_2222);
    xact(1'b1, 1'b0, 32'h14, 32'h0, lat, sw, sr);
    check_eq("after_abort_lat", 128'(lat), 128'(ExpLat));
    check_eq("after_abort_block", rd_block, blk1);

    // Reset in the middle of a write: old contents survive.
    xact(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, lat, sw, sr);
    check_eq("pre_wr40_lat", 128'(lat), 128'(ExpLat));
    mem_write_en = 1'b1;
    addr         = 32'h40;
    wr_data      = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_pulses", {126'd0, ready_to_read, finished_writing}, 128'd0);
    check_eq("midrst_rd_block", rd_block, 128'd0);
    mem_write_en = 1'b0;
    reset        = 1'b0;
    seen         = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ready_to_read || finished_writing) seen = 1'b1;
    end
    check_eq("midrst_no_late_pulse", {127'd0, seen}, 128'd0);
    xact(1'b1, 1'b0, 32'h40, 32'h0, lat, sw, sr);
    check_eq("midrst_readback", 128'(rd_block[31:0]), 128'hCAFE_F00D);

    // Address wrap: 0x1000 aliases word 0.
    xact(1'b0, 1'b1, 32'h1000, 32'hA5A5_A5A5, lat, sw, sr);
    check_eq("wrap_wr_lat", 128'(lat), 128'(ExpLat));
    xact(1'b1, 1'b0, 32'h0, 32'h0, lat, sw, sr);
    check_eq("wrap_readback", 128'(rd_block[31:0]), 128'hA5A5_A5A5);

    // Inputs change after acceptance: latched values are used.
    mem_write_en = 1'b1;
    addr         = 32'h50;
    wr_data      = 32'h0F0F_0F0F;
    @(posedge clk);
    #1;
    addr    = 32'h60;
    wr_data = 32'hBADB_AD00;
    lat     = 0;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (finished_writing) begin
        lat = n;
        break;
      end
    end
    mem_write_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("latch_wr_lat", 128'(lat), 128'(ExpLat));
    xact(1'b1, 1'b0, 32'h50, 32'h0, lat, sw, sr);
    check_eq("latch_readback", 128'(rd_block[31:0]), 128'h0F0F_0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_memory_resp.md
MAIN_MEMORY_RESP -- requirements
Module: main_memory_resp

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, SHALL be the backing-store size in 32-bit words (power of two).
REQ-002 Parameter BLOCK_WORDS, default 4, SHALL be the words per cache line returned on refill (power of two, 1..8).
REQ-003 Parameter LATENCY, default 4, SHALL be the cycles from request acceptance to completion pulse (1..15).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  in  1  SHALL be the reset; reset is synchronous and active-high.
REQ-006 mem_read_en  in  1  SHALL be the refill request from the cache controller, held until ready_to_read.
REQ-007 mem_write_en  in  1  SHALL be the write-through request, held until finished_writing.
REQ-008 addr  in  32  SHALL be the byte address of the request.
REQ-009 wr_data  in  32  SHALL be the word to store on write.
REQ-010 rd_block  out  32*BLOCK_WORDS  SHALL be the refill line, word 0 in bits [31:0].
REQ-011 ready_to_read  out  1  SHALL be the one-cycle refill-complete pulse.
REQ-012 finished_writing  out  1  SHALL be the one-cycle write-complete pulse.

Function
REQ-013 States SHALL be IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE.
REQ-014 Word index SHALL be addr[log2(MEM_DEPTH)+1:2]; upper address bits ignored (wrap modulo MEM_DEPTH).
REQ-015 In IDLE, mem_write_en high SHALL take priority over mem_read_en: latch addr and wr_data, load counter LATENCY-1, go WR_WAIT.
REQ-016 In IDLE, mem_read_en high and mem_write_en low SHALL latch block-aligned word index (low log2(BLOCK_WORDS) bits cleared), load counter LATENCY-1, go RD_WAIT.
REQ-017 In RD_WAIT/WR_WAIT the counter SHALL decrement each cycle; at count 0 go RD_DONE/WR_DONE respectively.
REQ-018 Transition RD_WAIT->RD_DONE SHALL register BLOCK_WORDS consecutive words from the latched index into rd_block.
REQ-019 Transition WR_WAIT->WR_DONE SHALL write the latched wr_data to the latched word; this is the only memory write.
REQ-020 ready_to_read SHALL be high exactly in RD_DONE, finished_writing exactly in WR_DONE; resulting latency: request sampled at edge T -> pulse in cycle after edge T+LATENCY.
REQ-021 RD_DONE and WR_DONE SHALL last one cycle and return to IDLE, ignoring requests in that cycle.
REQ-022 rd_block SHALL hold its value until the next refill completion.
REQ-023 If the active request (mem_read_en in RD_WAIT, mem_write_en in WR_WAIT) is low on a clock edge, the block SHALL abort to IDLE with no pulse and no memory write.
REQ-024 Latched address/data SHALL NOT change after acceptance even if addr/wr_data change.
REQ-025 Both outputs pulses SHALL never be high in the same cycle.

Reset
REQ-026 reset high at a rising edge SHALL force IDLE, counter 0, ready_to_read=0, finished_writing=0, rd_block=0, from any state, aborting any pending write.
REQ-027 Memory array contents SHALL NOT be cleared by reset.
REQ-028 Requests SHALL be ignored on the edge where reset is high; acceptance earliest on the first edge with reset low.

Verification
REQ-029 Write then read: write addr=0x10 data=0xDEADBEEF, LATENCY=4 -> finished_writing pulses 4 cycles after acceptance; refill addr=0x14 -> ready_to_read after 4 cycles, rd_block[31:0]=0xDEADBEEF (word 4, block 1).
REQ-030 Both enables high in IDLE with addr=0x20 -> write path taken, finished_writing only, ready_to_read stays 0.
REQ-031 Read dropped after 2 cycles -> no ready_to_read, state IDLE, next read accepted normally with full LATENCY.
REQ-032 Reset asserted mid WR_WAIT for write 0x12345678 to addr=0x40 -> outputs 0, later refill of 0x40 returns previous contents, not 0x12345678.
REQ-033 addr=0x1000 (MEM_DEPTH=1024) write 0xA5A5A5A5 -> refill of addr=0x0 returns 0xA5A5A5A5 in word 0 (wrap).
REQ-034 wr_data changed during WR_WAIT -> stored value equals data sampled at acceptance.
